param_comb_lock: RTL and testbench

PARAM_COMB_LOCK -- requirements
Module: param_comb_lock

---
 rtl/comb_lock_pkg.sv | 23 ++
 rtl/param_comb_lock_if.sv | 27 ++
 rtl/comb_lock_timer.sv | 28 ++
 rtl/param_comb_lock.sv | 176 +++++++++++++++++
 tb/tb_param_comb_lock.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/comb_lock_pkg.sv
// Shared types and sizing for the parameterised combination lock.
// No logic here; no latency or backpressure.
// State encoding, timer width and attempt-counter width helper.
package comb_lock_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    PROG_AUTH,
    PROG_NEW,
    GRANT,
    DENY,
    LOCK,
    PROG_DONE
  } state_t;

  localparam int TIMER_W = 32;

  function automatic int att_w(input int max_att);
    return (max_att < 1) ? 1 : $clog2(max_att + 1);
  endfunction

endpackage

// File: rtl/param_comb_lock_if.sv
// Keypad-side bundle of the combination lock: digit/program strobes in, status out.
// Wires only; no latency; no backpressure (strobes are fire-and-forget).
// master drives the strobes, slave is the lock.
interface param_comb_lock_if #(
  parameter int DIGIT_W = 4,
  parameter int ATT_W   = 2
);
  logic               digit_valid;
  logic [DIGIT_W-1:0] digit_in;
  logic               prog_req;
  logic               grant;
  logic               deny;
  logic               lock;
  logic               prog_done;
  logic               busy;
  logic [ATT_W-1:0]   attempts;

  modport master (
    output digit_valid, digit_in, prog_req,
    input  grant, deny, lock, prog_done, busy, attempts
  );

  modport slave (
    input  digit_valid, digit_in, prog_req,
    output grant, deny, lock, prog_done, busy, attempts
  );
endinterface

// File: rtl/comb_lock_timer.sv
// Loadable 32-bit down-counter shared by lockout and entry-timeout timing.
// Load takes effect next cycle; expired is combinational from the count.
// No backpressure; counter holds at zero until reloaded.
module comb_lock_timer
  import comb_lock_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               expired
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/param_comb_lock.sv
// Combination lock with lockout, entry timeout and in-field code programming.
// Verdict (grant/deny/prog_done) appears the cycle after the last digit strobe.
// No backpressure: strobes outside accepting states are silently dropped.
module param_comb_lock
  import comb_lock_pkg::*;
#(
  parameter int                          NUM_DIGITS    = 4,
  parameter int                          DIGIT_W       = 4,
  parameter int                          MAX_ATTEMPTS  = 3,
  parameter logic [TIMER_W-1:0]          LOCK_CYCLES   = 32'd300000000,
  parameter logic [TIMER_W-1:0]          ENTRY_TIMEOUT = 32'd100000000,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] DEFAULT_CODE = {4'd1, 4'd5, 4'd3, 4'd7}
) (
  input  logic             clk,
  input  logic             rst,
  param_comb_lock_if.slave bus
);

  localparam int CODE_W = NUM_DIGITS * DIGIT_W;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int AW     = att_w(MAX_ATTEMPTS);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                mism_q, mism_d;
  logic [AW-1:0]       att_q, att_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CODE_W-1:0]   shadow_q, shadow_d;

  logic                tmr_load;
  logic [TIMER_W-1:0]  tmr_val;
  logic                tmr_expired;

  int                  base;
  logic [DIGIT_W-1:0]  ref_dig;
  logic                dig_bad;
  logic                dig_miss;
  logic                last;
  logic                miss_all;

  comb_lock_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      mism_q   <= 1'b0;
      att_q    <= '0;
      code_q   <= DEFAULT_CODE;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mism_q   <= mism_d;
      att_q    <= att_d;
      code_q   <= code_d;
      shadow_q <= shadow_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mism_d   = mism_q;
    att_d    = att_q;
    code_d   = code_q;
    shadow_d = shadow_q;
    tmr_load = 1'b0;
    tmr_val  = ENTRY_TIMEOUT;

    // First digit lives in the most significant field.
    base     = (NUM_DIGITS - 1 - int'(idx_q)) * DIGIT_W;
    ref_dig  = code_q[base +: DIGIT_W];
    dig_bad  = (DIGIT_W == 4) && (int'(bus.digit_in) > 9);
    dig_miss = dig_bad || (bus.digit_in != ref_dig);
    last     = (int'(idx_q) == NUM_DIGITS - 1);
    miss_all = mism_q || dig_miss;

    case (state_q)
      IDLE: begin
        if (bus.prog_req) begin
          state_d  = PROG_AUTH;
          tmr_load = 1'b1;
        end else if (bus.digit_valid) begin
          mism_d = dig_miss;
          if (last) begin
            state_d = dig_miss ? DENY : GRANT;
          end else begin
            state_d  = ENTRY;
            idx_d    = idx_q + 1'b1;
            tmr_load = 1'b1;
          end
        end
      end
      ENTRY, PROG_AUTH: begin
        if (bus.digit_valid) begin
          mism_d = miss_all;
          if (!last) begin
            idx_d    = idx_q + 1'b1;
            tmr_load = 1'b1;
          end else if (miss_all) begin
            state_d = DENY;
          end else if (state_q == ENTRY) begin
            state_d = GRANT;
          end else begin
            state_d  = PROG_NEW;
            idx_d    = '0;
            tmr_load = 1'b1;
          end
        end else if (tmr_expired) begin
          state_d = IDLE;
        end
      end
      PROG_NEW: begin
        if (bus.digit_valid) begin
          if (dig_bad) begin
            state_d = IDLE;
          end else begin
            shadow_d[base +: DIGIT_W] = bus.digit_in;
            if (last) begin
              code_d  = shadow_d;
              state_d = PROG_DONE;
            end else begin
              idx_d    = idx_q + 1'b1;
              tmr_load = 1'b1;
            end
          end
        end else if (tmr_expired) begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        att_d   = '0;
        state_d = IDLE;
      end
      DENY: begin
        if (int'(att_q) < MAX_ATTEMPTS) att_d = att_q + 1'b1;
        if (int'(att_q) + 1 == MAX_ATTEMPTS) begin
          // Loaded one short so LOCK spans exactly LOCK_CYCLES cycles.
          state_d  = LOCK;
          tmr_load = 1'b1;
          tmr_val  = LOCK_CYCLES - 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      LOCK: begin
        if (tmr_expired) begin
          att_d   = '0;
          state_d = IDLE;
        end
      end
      PROG_DONE: state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    if (state_d == IDLE) begin
      idx_d  = '0;
      mism_d = 1'b0;
    end
  end

  assign bus.grant     = (state_q == GRANT);
  assign bus.deny      = (state_q == DENY);
  assign bus.lock      = (state_q == LOCK);
  assign bus.prog_done = (state_q == PROG_DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.attempts  = att_q;

endmodule

// File: tb/tb_param_comb_lock.sv
// Directed + randomized bench for param_comb_lock against a code/attempt-count model.
module tb_param_comb_lock;
  import comb_lock_pkg::*;

  localparam int LOCK_N = 20;
  localparam int TMO_N  = 10;
  localparam int MAXA   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  param_comb_lock_if #(.DIGIT_W(4), .ATT_W(att_w(MAXA))) bus ();

  param_comb_lock #(
    .LOCK_CYCLES   (32'd20),
    .ENTRY_TIMEOUT (32'd10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errs    = 0;
  int m_code[4];
  int m_att;
  int d[4];
  int nc[4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int dg);
    bus.digit_valid = 1'b1;
    bus.digit_in    = 4'(dg);
    tick();
    bus.digit_valid = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_grant"}, bus.grant, 0);
    chk({tag, "_deny"}, bus.deny, 0);
    chk({tag, "_lock"}, bus.lock, 0);
    chk({tag, "_prog_done"}, bus.prog_done, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_attempts"}, bus.attempts, 0);
  endtask

  task automatic wait_lock();
    int n = 0;
    while (bus.lock && n < 100) begin
      bus.digit_valid = (n % 3 == 0);
      bus.digit_in    = 4'(m_code[0]);
      n++;
      tick();
    end
    bus.digit_valid = 1'b0;
    chk("lock_len", n, LOCK_N);
    m_att = 0;
    chk("lock_exit_attempts", bus.attempts, 0);
    chk("lock_exit_busy", bus.busy, 0);
  endtask

  // Called while the verdict cycle is visible.
  task automatic after_verdict(input bit ok);
    tick();
    if (ok) m_att = 0;
    else    m_att = m_att + 1;
    chk("attempts", bus.attempts, m_att);
    if (m_att == MAXA) begin
      chk("lock_high", bus.lock, 1);
      wait_lock();
    end
  endtask

  task automatic try_code(input int dc[4], input int gap);
    bit ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (dc[i] != m_code[i]) ok = 1'b0;
      strobe(dc[i]);
      if (i < 3) begin
        chk("early_deny", bus.deny, 0);
        chk("entry_busy", bus.busy, 1);
        repeat (gap) tick();
      end
    end
    chk("verdict_grant", bus.grant, ok);
    chk("verdict_deny", bus.deny, !ok);
    after_verdict(ok);
  endtask

  task automatic program_code(input int auth[4], input int ncode[4], input int gap);
    bit ok = 1'b1;
    bus.prog_req = 1'b1;
    tick();
    bus.prog_req = 1'b0;
    chk("prog_busy", bus.busy, 1);
    for (int i = 0; i < 4; i++) begin
      repeat (gap) tick();
      if (auth[i] != m_code[i]) ok = 1'b0;
      strobe(auth[i]);
    end
    chk("auth_deny", bus.deny, !ok);
    if (!ok) begin
      after_verdict(1'b0);
      return;
    end
    chk("prog_new_busy", bus.busy, 1);
    for (int i = 0; i < 4; i++) begin
      repeat (gap) tick();
      strobe(ncode[i]);
      if (ncode[i] > 9) begin
        chk("prog_abort_busy", bus.busy, 0);
        chk("prog_abort_attempts", bus.attempts, m_att);
        return;
      end
    end
    chk("prog_done", bus.prog_done, 1);
    m_code = ncode;
    tick();
    chk("prog_done_pulse", bus.prog_done, 0);
    chk("prog_done_idle", bus.busy, 0);
  endtask

  initial begin
    bus.digit_valid = 1'b0;
    bus.digit_in    = '0;
    bus.prog_req    = 1'b0;
    m_code = '{1, 5, 3, 7};
    m_att  = 0;
    repeat (2) tick();
    chk_quiet("reset");
    rst = 1'b0;
    tick();
    chk_quiet("post_reset");

    try_code('{1, 5, 3, 7}, 0);
    try_code('{1, 9, 3, 7}, 1);
    try_code('{0, 0, 0, 0}, 0);
    try_code('{9, 5, 3, 7}, 2);

    program_code('{1, 5, 3, 7}, '{2, 4, 6, 8}, 0);
    try_code('{2, 4, 6, 8}, 0);
    try_code('{1, 5, 3, 7}, 0);
    try_code('{2, 4, 6, 8}, 3);

    // Partial entry followed by an over-long gap.
    strobe(m_code[0]);
    strobe(m_code[1]);
    for (int i = 0; i < TMO_N; i++) begin
      chk("tmo_no_deny", bus.deny, 0);
      tick();
    end
    chk("tmo_busy_at_limit", bus.busy, 1);
    tick();
    chk("tmo_busy_after", bus.busy, 0);
    chk("tmo_deny", bus.deny, 0);
    chk("tmo_attempts", bus.attempts, m_att);

    for (int t = 0; t < 30; t++) begin
      int op  = $urandom_range(0, 3);
      int gap = $urandom_range(0, TMO_N);
      d = m_code;
      case (op)
        0: try_code(d, gap);
        1: begin
          for (int i = 0; i < 4; i++) d[i] = $urandom_range(0, 15);
          try_code(d, gap);
        end
        2: begin
          d[$urandom_range(0, 3)] = $urandom_range(10, 15);
          try_code(d, gap);
        end
        default: begin
          for (int i = 0; i < 4; i++)
            nc[i] = ($urandom_range(0, 7) == 0) ? 12 : $urandom_range(0, 9);
          if ($urandom_range(0, 3) == 0) d[3] = (d[3] + 1) % 10;
          program_code(d, nc, gap);
        end
      endcase
    end

    // Reset during lockout.
    d = m_code;
    d[0] = (d[0] + 1) % 10;
    while (m_att < MAXA - 1) try_code(d, 0);
    for (int i = 0; i < 4; i++) strobe(d[i]);
    chk("pre_lock_deny", bus.deny, 1);
    repeat (4) tick();
    chk("in_lock", bus.lock, 1);
    rst = 1'b1;
    #1;
    chk_quiet("rst_in_lock");
    tick();
    rst = 1'b0;
    m_att  = 0;
    m_code = '{1, 5, 3, 7};
    tick();
    chk_quiet("after_rst_lock");

    // Reset part-way through entering a new code.
    program_code('{1, 5, 3, 7}, '{2, 4, 6, 8}, 0);
    bus.prog_req = 1'b1;
    tick();
    bus.prog_req = 1'b0;
    for (int i = 0; i < 4; i++) strobe(m_code[i]);
    strobe(9);
    strobe(9);
    chk("mid_prog_busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    chk_quiet("rst_mid_prog");
    tick();
    rst = 1'b0;
    m_att  = 0;
    m_code = '{1, 5, 3, 7};
    tick();
    try_code('{1, 5, 3, 7}, 0);
    try_code('{2, 4, 6, 8}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
